// File: rtl/serial_fifo_pkg.sv
// Register map constants shared by the memory-mapped serial port and its bench.
package serial_fifo_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int unsigned ST_RX_COUNT_LSB = 0;
    localparam int unsigned ST_TX_COUNT_LSB = 9;
    localparam int unsigned ST_COUNT_W      = 9;
    localparam int unsigned ST_RX_EMPTY     = 24;
    localparam int unsigned ST_TX_FULL      = 25;
    localparam int unsigned ST_RX_OVF       = 26;
    localparam int unsigned ST_TX_OVF       = 27;
    localparam int unsigned ST_RX_UNF       = 28;

    localparam int unsigned CTRL_RX_FLUSH  = 0;
    localparam int unsigned CTRL_TX_FLUSH  = 1;
    localparam int unsigned CTRL_CLR_FLAGS = 2;
    localparam int unsigned CTRL_LOOPBACK  = 3;

endpackage

// File: rtl/serial_fifo_mmio_if.sv
// Processor load/store bus seen by the memory-mapped serial port.
interface serial_fifo_mmio_if;

    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        wren_in;
    logic        rden_in;
    logic [31:0] data_out;

    modport master (output addr_in, data_in, wren_in, rden_in, input data_out);
    modport slave  (input addr_in, data_in, wren_in, rden_in, output data_out);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; flush has priority over push/pop.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/serial_fifo_mmio.sv
// Memory-mapped serial port with RX/TX FIFOs, STATUS/CTRL registers and sticky errors.
// Optional internal TX->RX loopback when SERIAL_FIFO_LOOPBACK_EN is defined.
module serial_fifo_mmio
    import serial_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic               clock,
    input  logic               reset,
    serial_fifo_mmio_if.slave  bus,
    input  logic [DATA_W-1:0]  serial_in,
    input  logic               serial_valid_in,
    output logic               serial_rden_out,
    output logic [DATA_W-1:0]  serial_out,
    input  logic               serial_ready_in,
    output logic               serial_wren_out
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              sel, rd_data, wr_data, wr_ctrl;
    logic [1:0]        off;
    logic              rx_flush, tx_flush, clr_flags;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [CW-1:0]     rx_count, tx_count;
    logic [DATA_W-1:0] rx_head, tx_head, rx_wdata;
    logic              rx_ovf_set, tx_ovf_set, rx_unf_set;
    logic              rx_ovf_q, tx_ovf_q, rx_unf_q;
    logic              unused_bits;

    assign sel       = (bus.addr_in[31:4] == BASE_ADDR[31:4]);
    assign off       = bus.addr_in[3:2];
    assign rd_data   = sel & bus.rden_in & (off == OFF_DATA);
    assign wr_data   = sel & bus.wren_in & (off == OFF_DATA);
    assign wr_ctrl   = sel & bus.wren_in & (off == OFF_CTRL);
    assign rx_flush  = wr_ctrl & bus.data_in[CTRL_RX_FLUSH];
    assign tx_flush  = wr_ctrl & bus.data_in[CTRL_TX_FLUSH];
    assign clr_flags = wr_ctrl & bus.data_in[CTRL_CLR_FLAGS];
    assign unused_bits = ^{bus.addr_in[1:0], bus.data_in};

    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_unf_set = rd_data & rx_empty;
    assign tx_push    = wr_data;
    assign tx_ovf_set = wr_data & tx_full & ~tx_pop;
    assign serial_out = tx_head;

`ifdef SERIAL_FIFO_LOOPBACK_EN
    logic loopback_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            loopback_q <= 1'b0;
        end else if (wr_ctrl) begin
            loopback_q <= bus.data_in[CTRL_LOOPBACK];
        end
    end

    // In loopback the TX head feeds RX directly and the external port is idle.
    assign tx_pop          = ~tx_empty & (loopback_q ? (~rx_full | rx_pop) : serial_ready_in);
    assign rx_push         = loopback_q ? tx_pop : serial_valid_in & (~rx_full | rx_pop);
    assign rx_wdata        = loopback_q ? tx_head : serial_in;
    assign serial_rden_out = ~loopback_q & rx_push;
    assign serial_wren_out = ~loopback_q & tx_pop;
    assign rx_ovf_set      = ~loopback_q & serial_valid_in & rx_full & ~rx_pop;
`else
    assign tx_pop          = ~tx_empty & serial_ready_in;
    assign rx_push         = serial_valid_in & (~rx_full | rx_pop);
    assign rx_wdata        = serial_in;
    assign serial_rden_out = rx_push;
    assign serial_wren_out = tx_pop;
    assign rx_ovf_set      = serial_valid_in & rx_full & ~rx_pop;
`endif

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .wdata (rx_wdata),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_head)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (bus.data_in[DATA_W-1:0]),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_head)
    );

    // A new error in the clearing cycle keeps its flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            rx_ovf_q <= (rx_ovf_q & ~clr_flags) | rx_ovf_set;
            tx_ovf_q <= (tx_ovf_q & ~clr_flags) | tx_ovf_set;
            rx_unf_q <= (rx_unf_q & ~clr_flags) | rx_unf_set;
        end
    end

    always_comb begin
        bus.data_out = '0;
        if (sel && bus.rden_in) begin
            case (off)
                OFF_DATA: bus.data_out = 32'(rx_head);
                OFF_STATUS: begin
                    bus.data_out[ST_RX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(rx_count);
                    bus.data_out[ST_TX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(tx_count);
                    bus.data_out[ST_RX_EMPTY] = rx_empty;
                    bus.data_out[ST_TX_FULL]  = tx_full;
                    bus.data_out[ST_RX_OVF]   = rx_ovf_q;
                    bus.data_out[ST_TX_OVF]   = tx_ovf_q;
                    bus.data_out[ST_RX_UNF]   = rx_unf_q;
                end
`ifdef SERIAL_FIFO_LOOPBACK_EN
                OFF_CTRL: bus.data_out[CTRL_LOOPBACK] = loopback_q;
`endif
                default: bus.data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fifo_mmio.sv
// Randomized self-checking bench for serial_fifo_mmio against a queue-based reference model.
module tb_serial_fifo_mmio;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 16;
    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'd4;
    localparam logic [31:0] A_CTRL   = BASE + 32'd8;
    localparam logic [31:0] A_OTHER  = 32'h1234_5670;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] serial_in;
    logic          serial_valid_in, serial_ready_in;
    logic          serial_rden_out, serial_wren_out;
    logic [DW-1:0] serial_out;

    serial_fifo_mmio_if bus ();

    always #5 clock = ~clock;

    serial_fifo_mmio #(.DATA_W(DW), .DEPTH(DP), .BASE_ADDR(BASE)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_rden_out (serial_rden_out),
        .serial_out      (serial_out),
        .serial_ready_in (serial_ready_in),
        .serial_wren_out (serial_wren_out)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] tx_q[$];
    bit            m_rx_ovf, m_tx_ovf, m_rx_unf, m_lb;
    logic [31:0]   last_dout;
    logic [DW-1:0] last_sout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_word();
        logic [8:0] rc, tc;
        rc = 9'(rx_q.size());
        tc = 9'(tx_q.size());
        return {3'b0, m_rx_unf, m_tx_ovf, m_rx_ovf, tx_q.size() == DP, rx_q.size() == 0,
                6'b0, tc, rc};
    endfunction

    // One bus cycle: drive, check at negedge against the model, advance the model, clock.
    task automatic step(input logic [31:0] addr, input logic [31:0] wdata, input bit wren,
                        input bit rden);
        bit            sel, rd_data, wr_data, wr_ctrl, pop, drain, rx_push, tx_accept;
        bit            rx_full, tx_full, exp_rden, exp_wren, ovf_rx, ovf_tx, unf;
        logic [1:0]    off;
        logic [DW-1:0] rx_head, tx_head, rx_word;
        logic [31:0]   exp_dout;
        bus.addr_in = addr;
        bus.data_in = wdata;
        bus.wren_in = wren;
        bus.rden_in = rden;
        @(negedge clock);
        sel     = (addr[31:4] == BASE[31:4]);
        off     = addr[3:2];
        rd_data = sel && rden && off == 2'd0;
        wr_data = sel && wren && off == 2'd0;
        wr_ctrl = sel && wren && off == 2'd2;
        rx_full = rx_q.size() == DP;
        tx_full = tx_q.size() == DP;
        rx_head = (rx_q.size() > 0) ? rx_q[0] : '0;
        tx_head = (tx_q.size() > 0) ? tx_q[0] : '0;
        pop     = rd_data && rx_q.size() > 0;
        if (m_lb) begin
            drain    = tx_q.size() > 0 && (!rx_full || pop);
            rx_push  = drain;
            rx_word  = tx_head;
            exp_rden = 1'b0;
            exp_wren = 1'b0;
            ovf_rx   = 1'b0;
        end else begin
            drain    = tx_q.size() > 0 && serial_ready_in;
            rx_push  = serial_valid_in && (!rx_full || pop);
            rx_word  = serial_in;
            exp_rden = rx_push;
            exp_wren = drain;
            ovf_rx   = serial_valid_in && rx_full && !pop;
        end
        tx_accept = wr_data && (!tx_full || drain);
        ovf_tx    = wr_data && tx_full && !drain;
        unf       = rd_data && rx_q.size() == 0;
        exp_dout  = 32'd0;
        if (sel && rden) begin
            case (off)
                2'd0: exp_dout = 32'(rx_head);
                2'd1: exp_dout = status_word();
                2'd2: exp_dout = m_lb ? 32'd8 : 32'd0;
                default: exp_dout = 32'd0;
            endcase
        end
        check_eq("data_out", bus.data_out, exp_dout);
        check_eq("serial_rden_out", 32'(serial_rden_out), 32'(exp_rden));
        check_eq("serial_wren_out", 32'(serial_wren_out), 32'(exp_wren));
        check_eq("serial_out", 32'(serial_out), 32'(tx_head));
        last_dout = bus.data_out;
        last_sout = serial_out;
        if (pop) void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rx_word);
        if (drain) void'(tx_q.pop_front());
        if (tx_accept) tx_q.push_back(wdata[DW-1:0]);
        if (wr_ctrl && wdata[2]) begin
            m_rx_ovf = 1'b0;
            m_tx_ovf = 1'b0;
            m_rx_unf = 1'b0;
        end
        m_rx_ovf |= ovf_rx;
        m_tx_ovf |= ovf_tx;
        m_rx_unf |= unf;
        if (wr_ctrl && wdata[0]) rx_q.delete();
        if (wr_ctrl && wdata[1]) tx_q.delete();
`ifdef SERIAL_FIFO_LOOPBACK_EN
        if (wr_ctrl) m_lb = wdata[3];
`endif
        @(posedge clock);
        #1;
    endtask

    task automatic random_phase(input int cycles, input int unsigned vpct, input int unsigned rpct);
        logic [31:0] a, d;
        for (int n = 0; n < cycles; n++) begin
            a = ($urandom_range(0, 7) == 0) ? A_OTHER : BASE + 32'($urandom_range(0, 3)) * 32'd4;
            d = $urandom;
            if (a == A_CTRL && $urandom_range(0, 7) != 0) d[1:0] = 2'b00;
            serial_in       = DW'($urandom);
            serial_valid_in = $urandom_range(0, 99) < vpct;
            serial_ready_in = $urandom_range(0, 99) < rpct;
            step(a, d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.addr_in = '0;
        bus.data_in = '0;
        bus.wren_in = 1'b0;
        bus.rden_in = 1'b0;
        serial_in = '0;
        serial_valid_in = 1'b0;
        serial_ready_in = 1'b0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        bus.addr_in = A_STATUS;
        bus.rden_in = 1'b1;
        @(negedge clock);
        check_eq("rst_status", bus.data_out, 32'h0100_0000);
        check_eq("rst_wren", 32'(serial_wren_out), 32'd0);
        check_eq("rst_sout", 32'(serial_out), 32'd0);
        bus.rden_in = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // RX overflow on the 17th word, then in-order drain.
        serial_valid_in = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            serial_in = DW'(i);
            step(A_OTHER, 32'd0, 1'b0, 1'b0);
        end
        serial_valid_in = 1'b0;
        step(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("ovf_rx_count", 32'(last_dout[8:0]), 32'd16);
        check_eq("ovf_rx_flag", 32'(last_dout[26]), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step(A_DATA, 32'd0, 1'b0, 1'b1);
            check_eq("rx_order", last_dout, 32'(i));
        end

        // TX held, then released.
        step(A_DATA, 32'h0000_00A5, 1'b1, 1'b0);
        step(A_DATA, 32'h0000_005A, 1'b1, 1'b0);
        step(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("tx_count2", 32'(last_dout[17:9]), 32'd2);
        serial_ready_in = 1'b1;
        step(A_OTHER, 32'd0, 1'b0, 1'b0);
        check_eq("tx_first", 32'(last_sout), 32'h0000_00A5);
        step(A_OTHER, 32'd0, 1'b0, 1'b0);
        check_eq("tx_second", 32'(last_sout), 32'h0000_005A);
        serial_ready_in = 1'b0;

        // Underflow, then clear the sticky flags.
        step(A_DATA, 32'd0, 1'b0, 1'b1);
        check_eq("unf_data", last_dout, 32'd0);
        step(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("unf_flag", 32'(last_dout[28]), 32'd1);
        step(A_CTRL, 32'h4, 1'b1, 1'b0);
        step(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("flags_clr", 32'(last_dout[28:26]), 32'd0);

        // Store into a full TX FIFO while it drains.
        for (int i = 0; i < 16; i++) step(A_DATA, $urandom, 1'b1, 1'b0);
        serial_ready_in = 1'b1;
        step(A_DATA, 32'h77, 1'b1, 1'b0);
        step(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("full_tx_count", 32'(last_dout[17:9]), 32'd16);
        check_eq("full_tx_ovf", 32'(last_dout[27]), 32'd0);
        serial_ready_in = 1'b0;
        step(A_CTRL, 32'h3, 1'b1, 1'b0);

`ifdef SERIAL_FIFO_LOOPBACK_EN
        step(A_CTRL, 32'h8, 1'b1, 1'b0);
        step(A_DATA, 32'h3C, 1'b1, 1'b0);
        step(A_OTHER, 32'd0, 1'b0, 1'b0);
        step(A_DATA, 32'd0, 1'b0, 1'b1);
        check_eq("loopback_data", last_dout, 32'h3C);
        step(A_CTRL, 32'h3, 1'b1, 1'b0);
`endif

        random_phase(1000, 50, 50);
        random_phase(800, 90, 20);
        random_phase(800, 20, 90);

        // Asynchronous reset mid-traffic empties everything.
        serial_valid_in = 1'b1;
        serial_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) step(A_DATA, $urandom, 1'b1, 1'b0);
        reset = 1'b0;
        rx_q.delete();
        tx_q.delete();
        m_rx_ovf = 1'b0;
        m_tx_ovf = 1'b0;
        m_rx_unf = 1'b0;
        m_lb = 1'b0;
        serial_valid_in = 1'b0;
        step(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("midrst_status", last_dout, 32'h0100_0000);
        reset = 1'b1;
        random_phase(400, 60, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
